// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain: state encoding and the width
// derivations that must agree between the systolic array top and the drain.
package result_drain_pkg;

  // Drain state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each accumulated result element is wide enough for N products of two BW operands.
  function automatic int resWidth(input int bw, input int n);
    return n * 2 * bw;
  endfunction

endpackage

// File: rtl/res_saturate.sv
// Unsigned saturation of a wide result element to the streamed output width.
module res_saturate #(
  parameter int RES_BW = 80,
  parameter int OUT_BW = 32
) (
  input  logic [RES_BW-1:0] iRes,
  output logic [OUT_BW-1:0] oSat
);

  if (OUT_BW >= RES_BW) begin : gZext
    assign oSat = OUT_BW'(iRes);
  end else begin : gClamp
    assign oSat = (|iRes[RES_BW-1:OUT_BW]) ? {OUT_BW{1'b1}} : iRes[OUT_BW-1:0];
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots the systolic array result matrix on the finished rise and streams
// it row-major over valid/ready, one element per transfer.
//
//   state  | meaning
//   IDLE   | waiting for a rising edge of iFinished
//   STREAM | presenting buffered elements, advancing on each transfer
//   DONE   | all N*N elements transferred; held until reset
module result_drain
  import result_drain_pkg::*;
#(
  parameter int BW = 8,
  parameter int N = 5,
  parameter int OUT_BW = 32,
  localparam int RES_BW = resWidth(BW, N),
  localparam int IW = idxWidth(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RES_BW-1:0] iRes [0:N-1][0:N-1],
  input  logic              iFinished,
  output logic [OUT_BW-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic [IW-1:0]     oRowIdx,
  output logic [IW-1:0]     oColIdx,
  output logic              oLast,
  output logic              oBusy,
  output logic              oDone
);

  logic [1:0]        state;
  logic              finPrev;
  logic              finRise;
  logic              capture;
  logic              xfer;
  logic              lastElem;
  logic [IW-1:0]     rowCnt;
  logic [IW-1:0]     colCnt;
  logic [RES_BW-1:0] resBuf [0:N-1][0:N-1];
  logic [OUT_BW-1:0] satData;

  assign finRise  = iFinished & ~finPrev;
  assign capture  = (state == IDLE) & finRise;
  assign xfer     = (state == STREAM) & iReady;
  assign lastElem = (rowCnt == IW'(N - 1)) && (colCnt == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finPrev <= 1'b0;
      state   <= IDLE;
      rowCnt  <= '0;
      colCnt  <= '0;
    end else begin
      finPrev <= iFinished;
      case (state)
        IDLE: begin
          if (finRise) begin
            state  <= STREAM;
            rowCnt <= '0;
            colCnt <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (lastElem) begin
              state  <= DONE;
              rowCnt <= '0;
              colCnt <= '0;
            end else if (colCnt == IW'(N - 1)) begin
              colCnt <= '0;
              rowCnt <= rowCnt + 1'b1;
            end else begin
              colCnt <= colCnt + 1'b1;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer needs no reset: it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (capture) resBuf <= iRes;
  end

  res_saturate #(
    .RES_BW(RES_BW),
    .OUT_BW(OUT_BW)
  ) uSat (
    .iRes(resBuf[rowCnt][colCnt]),
    .oSat(satData)
  );

  // Outputs decode straight from registers, so a stall holds them stable and
  // an async reset clears them without waiting for a clock.
  assign oValid  = (state == STREAM);
  assign oBusy   = oValid;
  assign oDone   = (state == DONE);
  assign oLast   = oValid & lastElem;
  assign oData   = oValid ? satData : '0;
  assign oRowIdx = rowCnt;
  assign oColIdx = colCnt;

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream consumer of the systolic-array top level.
- Waits for the array's finished flag, then snapshots the full N x N result matrix into a local buffer.
- Streams the results out one element per handshake, row-major, on a valid/ready interface, with optional unsigned saturation to a narrower output width.
- Frees the array outputs as soon as the snapshot is taken; the next stage (memory writer / host bridge) sees a simple element stream.

Parameters:
- BW, 8, operand element width; must match the systolic array.
- N, 5, matrix dimension; must match the systolic array.
- RES_BW, N*2*BW, width of each incoming result element (derived; not overridden).
- OUT_BW, 32, width of each streamed element; 1 <= OUT_BW.

Ports:
- clk  input  1  clock, posedge-triggered.
- rst_n  input  1  asynchronous active-low reset.
- iRes  input  [RES_BW-1:0] x [0:N-1][0:N-1]  result matrix from the systolic array (unpacked 2-D, same shape as the array's oRes).
- iFinished  input  1  array finished flag; level, stays high until reset.
- oData  output  OUT_BW  current streamed element.
- oValid  output  1  oData/oRowIdx/oColIdx/oLast are valid.
- iReady  input  1  downstream accepts the element this cycle.
- oRowIdx  output  $clog2(N) (min 1)  row index of the current element.
- oColIdx  output  $clog2(N) (min 1)  column index of the current element.
- oLast  output  1  current element is (N-1,N-1).
- oBusy  output  1  high while in STREAM.
- oDone  output  1  sticky; high after the last element is transferred.

Behaviour:
- Reset (async, rst_n=0): state IDLE; oValid, oLast, oBusy and oDone = 0; oData, oRowIdx and oColIdx = 0; finPrev = 0. Snapshot buffer contents are don't-care.
- Edge detect: finPrev <= iFinished every cycle; finRise = iFinished & ~finPrev. iFinished already high on the first cycle after reset counts as a rise.
- States: IDLE, STREAM, DONE.
- IDLE -> STREAM on the posedge where finRise=1. At that edge:
  - all N*N iRes elements are copied into the buffer;
  - row/col counters are set to 0;
  - oValid=1, oBusy=1, oData = sat(buf[0][0]).
  - Latency: oValid rises one clock after iFinished is first sampled high.
- STREAM:
  - A transfer occurs when oValid & iReady.
  - On a transfer, advance col; when col wraps N-1 -> 0, advance row.
  - oData and the indices update at the same edge to the next element.
  - While oValid & ~iReady, all outputs hold stable; no drop, no duplicate.
  - oLast = 1 exactly while the presented element is (N-1,N-1).
- STREAM -> DONE on the transfer of the last element. At that edge oValid=0, oLast=0, oBusy=0, oDone=1.
- DONE: held until reset. finRise is ignored in STREAM and DONE, so no re-capture.
- Saturation sat(x):
  - If OUT_BW >= RES_BW: zero-extend.
  - Else: x > 2^OUT_BW-1 gives all-ones; otherwise the low OUT_BW bits.
  - Values are unsigned.
- Throughput: with iReady tied high, N*N consecutive beats, one element per clock.
- Reset mid-stream: immediate return to IDLE with reset values; a subsequent finRise restarts from (0,0).

Decomposition:
- Shared package result_drain_pkg holds:
  - state enum {IDLE, STREAM, DONE};
  - localparam function for the index width (max(1,$clog2(N)));
  - the RES_BW derivation, so the array top and the drain agree.
- One sub-module: res_saturate (combinational; parameters RES_BW and OUT_BW; input [RES_BW-1:0], output [OUT_BW-1:0]). It is instantiated once on the buffer read path.
- Snapshot buffer and counters stay in result_drain.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> oValid=0, oDone=0, oBusy=0, oData=0 asynchronously, before the next clk edge.
2. Normal stream (BW=8, N=5, iReady=1): iRes[i][j]=5i+j, raise iFinished -> 25 beats on consecutive clocks, oData=0..24, indices match, oLast only on beat 25 (value 24). oDone=1 the cycle after; oValid=0 thereafter.
3. Backpressure: iReady pattern 1,0,0,1,0,1... -> exactly 25 transfers, same 0..24 sequence; oData/indices stable during every stall cycle.
4. Saturation (OUT_BW=16): iRes[2][3]=70000, iRes[0][0]=65535 -> beat 14 oData=65535, beat 1 oData=65535. An element of 300 passes as 300.
5. Snapshot isolation: change iRes to all 7 one cycle after the capture edge -> the stream still outputs the original 0..24.
6. Reset mid-stream: pulse rst_n low after 10 transfers -> outputs return to reset values. Re-raise iFinished -> stream restarts at (0,0) with oData=0. A second iFinished toggle in DONE produces no new beats.
